// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS5 (x^5+x^2+1) pattern checker.
package prbs_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int PRBS_W = 5;
  localparam int TAP_A  = 4;
  localparam int TAP_B  = 2;

  // Generator reset seed; the checker itself never loads it.
  localparam logic [PRBS_W-1:0] GEN_SEED = 5'b11111;

  // s(n) = s(n-5) ^ s(n-3), with h[0] the newest bit.
  function automatic logic predict(input logic [PRBS_W-1:0] h);
    return h[TAP_A] ^ h[TAP_B];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clear wins over a same-cycle increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/prbs5_checker.sv
// PRBS5 receive checker: seeds from the line, confirms sync, then flywheels
// a local predictor and reports per-bit mismatches with burst loss-of-lock.
module prbs5_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int WIN      = 31,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  input  logic             err_cnt_clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int SEED_W  = 3;
  localparam int MATCH_W = 8;
  localparam int WIN_W   = $clog2(WIN + 1);
  localparam int EWIN_W  = $clog2(LOSS_CNT + 1);

  localparam logic [SEED_W-1:0]  SEED_LAST = SEED_W'(PRBS_W - 1);
  localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WIN - 1);
  localparam logic [EWIN_W-1:0]  LOSS_V    = EWIN_W'(LOSS_CNT);

  state_e              state_q;
  logic [PRBS_W-1:0]   hist_q;
  logic [SEED_W-1:0]   seed_q;
  logic [MATCH_W-1:0]  match_q;
  logic [WIN_W-1:0]    win_q;
  logic [EWIN_W-1:0]   ewin_q;
  logic                locked_q;
  logic                err_q;

  logic                pred;
  logic                mis;
  logic [PRBS_W-1:0]   hist_din;
  logic [PRBS_W-1:0]   hist_pred;
  logic [EWIN_W-1:0]   ewin_nxt;
  logic                cnt_inc;

  assign pred      = predict(hist_q);
  assign mis       = din ^ pred;
  assign hist_din  = {hist_q[PRBS_W-2:0], din};
  assign hist_pred = {hist_q[PRBS_W-2:0], pred};
  assign ewin_nxt  = ewin_q + EWIN_W'(mis);
  assign cnt_inc   = din_vld && (state_q == LOCKED) && mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEED;
      hist_q   <= '0;
      seed_q   <= '0;
      match_q  <= '0;
      win_q    <= '0;
      ewin_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (din_vld) begin
        unique case (state_q)
          SEED: begin
            hist_q <= hist_din;
            if (seed_q == SEED_LAST) begin
              state_q <= SYNC;
              seed_q  <= '0;
              match_q <= '0;
            end else begin
              seed_q <= seed_q + 1'b1;
            end
          end
          SYNC: begin
            hist_q <= hist_din;
            // An all-zero history can never leave zero; restart seeding.
            if (hist_din == '0) begin
              state_q <= SEED;
              seed_q  <= '0;
              match_q <= '0;
            end else if (mis) begin
              match_q <= '0;
            end else if (match_q == LOCK_LAST) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              match_q  <= '0;
              win_q    <= '0;
              ewin_q   <= '0;
            end else begin
              match_q <= match_q + 1'b1;
            end
          end
          LOCKED: begin
            // Flywheel on the prediction so a single bad bit costs one error.
            hist_q <= hist_pred;
            err_q  <= mis;
            if (ewin_nxt == LOSS_V) begin
              state_q  <= SEED;
              locked_q <= 1'b0;
              seed_q   <= '0;
              win_q    <= '0;
              ewin_q   <= '0;
            end else if (win_q == WIN_LAST) begin
              win_q  <= '0;
              ewin_q <= '0;
            end else begin
              win_q  <= win_q + 1'b1;
              ewin_q <= ewin_nxt;
            end
          end
          default: begin
            state_q  <= SEED;
            locked_q <= 1'b0;
            seed_q   <= '0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (cnt_inc),
    .clr_i (err_cnt_clr),
    .cnt_o (err_cnt)
  );

  assign locked = locked_q;
  assign err    = err_q;

endmodule

// File: tb/tb_prbs5_checker.sv
// Self-checking bench for prbs5_checker: vector tables fed through a scoreboard queue.
module tb_prbs5_checker;

  localparam int CNT_W = 4;

  typedef struct {
    logic             din;
    logic             vld;
    logic             clr;
    logic             e_err;
    logic             e_lock;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             din = 1'b0;
  logic             din_vld = 1'b0;
  logic             err_cnt_clr = 1'b0;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  int    total = 0;
  int    bad   = 0;
  string tname = "reset";
  int    step_no = 0;

  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t mv;

  // Reference stream generator: first five bits 1,1,1,0,0 then the recurrence.
  logic [4:0] gh;
  logic [0:4] ginit;
  int         gn;

  prbs5_checker #(
    .LOCK_CNT (8),
    .LOSS_CNT (4),
    .WIN      (31),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_vld     (din_vld),
    .err_cnt_clr (err_cnt_clr),
    .locked      (locked),
    .err         (err),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no summary, want finish");
    $fatal(1, "timeout");
  end

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mv = exp_q.pop_front();
      step_no++;
      total++;
      if (err !== mv.e_err || locked !== mv.e_lock || err_cnt !== mv.e_cnt) begin
        bad++;
        $display("FAIL %s step %0d: got err=%b locked=%b cnt=%0d, want err=%b locked=%b cnt=%0d",
                 tname, step_no, err, locked, err_cnt, mv.e_err, mv.e_lock, mv.e_cnt);
      end
    end
  end

  task automatic gen_reset();
    gn    = 0;
    gh    = '0;
    ginit = 5'b11100;
  endtask

  task automatic gen(output logic b);
    b  = (gn < 5) ? ginit[gn] : (gh[4] ^ gh[2]);
    gh = {gh[3:0], b};
    gn++;
  endtask

  task automatic add(input logic d, input logic v, input logic c,
                     input logic ee, input logic el, input logic [CNT_W-1:0] ec);
    vec_t r;
    r.din = d; r.vld = v; r.clr = c; r.e_err = ee; r.e_lock = el; r.e_cnt = ec;
    vecs.push_back(r);
  endtask

  task automatic run_vecs(input string name);
    tname   = name;
    step_no = 0;
    foreach (vecs[i]) begin
      @(negedge clk);
      din         = vecs[i].din;
      din_vld     = vecs[i].vld;
      err_cnt_clr = vecs[i].clr;
      exp_q.push_back(vecs[i]);
    end
    @(posedge clk);
    #2;
    din_vld     = 1'b0;
    err_cnt_clr = 1'b0;
    vecs.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; din = 1'b0; din_vld = 1'b0; err_cnt_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    gen_reset();
  endtask

  task automatic chk_outs(input string name);
    total++;
    if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== '0) begin
      bad++;
      $display("FAIL %s: got err=%b locked=%b cnt=%0d, want all zero", name, err, locked, err_cnt);
    end
  endtask

  initial begin
    logic             b, f, c, lk, v;
    logic [CNT_W-1:0] cnt;
    int               vc, k, ne, off;

    #3;
    chk_outs("reset_state");
    do_reset();

    // Clean lock from reset.
    for (int i = 1; i <= 200; i++) begin
      gen(b);
      add(b, 1'b1, 1'b0, 1'b0, i >= 13, '0);
    end
    run_vecs("clean_lock");

    // Single corrupted bit while locked.
    do_reset();
    cnt = '0;
    for (int i = 1; i <= 80; i++) begin
      gen(b);
      f = (i == 40);
      if (f) cnt = 1;
      add(b ^ f, 1'b1, 1'b0, f, i >= 13, cnt);
    end
    run_vecs("single_err");

    // Four errors in one window force loss; clean stream relocks 13 bits later.
    do_reset();
    cnt = '0;
    for (int i = 1; i <= 50; i++) begin
      gen(b);
      f = (i == 16 || i == 18 || i == 20 || i == 22);
      if (f) cnt = cnt + 1'b1;
      lk = (i >= 13 && i < 22) || (i >= 35);
      add(b ^ f, 1'b1, 1'b0, f, lk, cnt);
    end
    run_vecs("burst_loss");

    // Random stalls, then an error with a same-cycle clear.
    do_reset();
    cnt = '0;
    vc  = 0;
    while (vc < 40) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        gen(b);
        vc++;
        f = (vc == 18 || vc == 23);
        c = (vc == 23);
        if (c) cnt = '0;
        else if (f) cnt = cnt + 1'b1;
        add(b ^ f, 1'b1, c, f, vc >= 13, cnt);
      end else begin
        add(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, vc >= 13, cnt);
      end
    end
    run_vecs("stall_clr");

    // All-zero input never locks; a real stream then locks on its 13th bit.
    do_reset();
    for (int i = 0; i < 40; i++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    gen_reset();
    for (int j = 0; j < 30; j++) begin
      gen(b);
      add(b, 1'b1, 1'b0, 1'b0, j >= 12, '0);
    end
    run_vecs("all_zero");

    // Spread errors saturate the 4-bit counter without losing lock.
    do_reset();
    cnt = '0; ne = 0; k = 0;
    while (ne < 20) begin
      k++;
      gen(b);
      off = k - 14;
      f = (k >= 14) && ((off % 31) == 5 || (off % 31) == 15 || (off % 31) == 25);
      if (f) begin
        ne++;
        if (cnt != {CNT_W{1'b1}}) cnt = cnt + 1'b1;
      end
      add(b ^ f, 1'b1, 1'b0, f, k >= 13, cnt);
    end
    run_vecs("saturate");

    // Asynchronous reset mid-stream, checked before any clock edge.
    rst = 1'b1;
    #1;
    chk_outs("async_reset");
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
